uart_rx_fifo: RTL and testbench

//  Parametrised UART receiver, successor to the fixed 8N1 4x-oversampled receiver.

---
 rtl/uart_rx_fifo_if.sv | 35 +++
 rtl/uart_rx_fifo.sv | 232 +++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// Receive-side bus between the UART receiver and the peripheral register block.
//   master : the receiver; drives head-of-FIFO data, flags and occupancy,
//            and samples rxready.
//   slave  : the consumer; samples the receiver outputs and drives rxready
//            to pop the head entry.
// Signals:
//   rxdata      head entry data (0 when empty)
//   rxvalid     FIFO not empty
//   rxready     pop request from consumer
//   frame_err   head entry had a bad stop bit
//   parity_err  head entry had a parity mismatch
//   overrun     sticky: a frame was dropped because the FIFO was full
//   fifo_count  entries held
interface uart_rx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  logic [DATA_BITS-1:0]          rxdata;
  logic                          rxvalid;
  logic                          rxready;
  logic                          frame_err;
  logic                          parity_err;
  logic                          overrun;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;

  modport master (
    output rxdata, rxvalid, frame_err, parity_err, overrun, fifo_count,
    input  rxready
  );

  modport slave (
    input  rxdata, rxvalid, frame_err, parity_err, overrun, fifo_count,
    output rxready
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Parametrised UART receiver with 3-sample majority voting, optional parity,
// 1 or 2 stop bits and a first-word-fall-through receive FIFO with sticky
// overrun detection.
// Ports:
//   i_clk         system clock
//   i_reset       asynchronous reset, active-high
//   i_rxclken     oversample tick, OVS ticks per bit
//   i_rx          asynchronous serial line, idle high
//   i_rxclear     synchronous clear of FSM, FIFO and flags
//   i_parity_en   parity bit expected after data (latched per frame)
//   i_parity_odd  odd parity when 1, even when 0 (latched per frame)
//   rx_bus        FIFO head / handshake interface (master side)
//
// state  | meaning
// IDLE   | waiting for a low sample on a tick
// START  | validating the start bit; high mid-bit vote rejects it as a glitch
// DATA   | sampling DATA_BITS data bits, LSB first
// PARITY | sampling the parity bit
// STOP   | sampling stop bits; push at mid-bit of the last one
// BRK    | all-zero frame received; wait for the line to return high
module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int OVS        = 16,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_rxclken,
  input  logic           i_rx,
  input  logic           i_rxclear,
  input  logic           i_parity_en,
  input  logic           i_parity_odd,
  uart_rx_fifo_if.master rx_bus
);

  localparam int TW = $clog2(OVS);
  localparam int IW = $clog2(DATA_BITS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_BITS + 2;

  localparam logic [TW-1:0] T_S0  = TW'(OVS/2 - 1);
  localparam logic [TW-1:0] T_S1  = TW'(OVS/2);
  localparam logic [TW-1:0] T_MID = TW'(OVS/2 + 1);
  localparam logic [TW-1:0] T_END = TW'(OVS - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic [PW:0]   FULL_CNT  = (PW+1)'(FIFO_DEPTH);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic [2:0] BRK    = 3'd5;

  logic                 rx_m, rx_s;
  logic [2:0]           state;
  logic [TW-1:0]        tcnt;
  logic [IW-1:0]        idx;
  logic                 sidx;
  logic                 s0, s1;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr_r, ferr_r, seen_one;
  logic                 par_en_r, par_odd_r;

  logic                 maj, ferr_now, is_break, push;
  logic [EW-1:0]        push_entry;

  logic [EW-1:0]        mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [PW:0]          count;
  logic                 overrun;
  logic                 pop, full, do_push;
  logic [EW-1:0]        head;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else if (i_rxclear) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= i_rx;
      rx_s <= rx_m;
    end
  end

  // The third vote is the live sample taken on the mid tick itself.
  always_comb begin
    maj        = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
    ferr_now   = ferr_r | ~maj;
    is_break   = ~(seen_one | maj);
    push       = i_rxclken && (state == STOP) && (tcnt == T_MID) && (sidx == LAST_STOP);
    push_entry = {ferr_now, perr_r, shreg};
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= IDLE;
      tcnt      <= '0;
      idx       <= '0;
      sidx      <= 1'b0;
      s0        <= 1'b1;
      s1        <= 1'b1;
      shreg     <= '0;
      perr_r    <= 1'b0;
      ferr_r    <= 1'b0;
      seen_one  <= 1'b0;
      par_en_r  <= 1'b0;
      par_odd_r <= 1'b0;
    end else if (i_rxclear) begin
      state     <= IDLE;
      tcnt      <= '0;
      idx       <= '0;
      sidx      <= 1'b0;
      s0        <= 1'b1;
      s1        <= 1'b1;
      shreg     <= '0;
      perr_r    <= 1'b0;
      ferr_r    <= 1'b0;
      seen_one  <= 1'b0;
      par_en_r  <= 1'b0;
      par_odd_r <= 1'b0;
    end else if (i_rxclken) begin
      if (state != IDLE && state != BRK) begin
        tcnt <= (tcnt == T_END) ? '0 : tcnt + 1'b1;
        if (tcnt == T_S0) s0 <= rx_s;
        if (tcnt == T_S1) s1 <= rx_s;
      end
      case (state)
        IDLE: begin
          if (!rx_s) begin
            // The detecting tick is tick 0 of the start bit.
            state     <= START;
            tcnt      <= TW'(1);
            idx       <= '0;
            sidx      <= 1'b0;
            perr_r    <= 1'b0;
            ferr_r    <= 1'b0;
            seen_one  <= 1'b0;
            par_en_r  <= i_parity_en;
            par_odd_r <= i_parity_odd;
          end
        end
        START: begin
          if (tcnt == T_MID && maj) state <= IDLE;
          else if (tcnt == T_END)   state <= DATA;
        end
        DATA: begin
          if (tcnt == T_MID) begin
            shreg[idx] <= maj;
            seen_one   <= seen_one | maj;
          end
          if (tcnt == T_END) begin
            if (idx == LAST_IDX) begin
              idx   <= '0;
              state <= par_en_r ? PARITY : STOP;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        PARITY: begin
          if (tcnt == T_MID) begin
            perr_r   <= ((^shreg) ^ maj) != par_odd_r;
            seen_one <= seen_one | maj;
          end
          if (tcnt == T_END) state <= STOP;
        end
        STOP: begin
          if (tcnt == T_MID) begin
            ferr_r   <= ferr_now;
            seen_one <= seen_one | maj;
            // Leave at mid-bit of the last stop bit to tolerate baud skew.
            if (sidx == LAST_STOP) state <= is_break ? BRK : IDLE;
          end
          if (tcnt == T_END) sidx <= ~sidx;
        end
        BRK: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    pop     = rx_bus.rxready && (count != '0);
    full    = (count == FULL_CNT);
    do_push = push && (!full || pop);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else if (i_rxclear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push && full && !pop) overrun <= 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push && !i_rxclear) mem[wr_ptr] <= push_entry;
  end

  always_comb begin
    head                = mem[rd_ptr];
    rx_bus.rxvalid      = (count != '0);
    rx_bus.rxdata       = rx_bus.rxvalid ? head[DATA_BITS-1:0] : '0;
    rx_bus.parity_err   = rx_bus.rxvalid ? head[DATA_BITS]     : 1'b0;
    rx_bus.frame_err    = rx_bus.rxvalid ? head[DATA_BITS+1]   : 1'b0;
    rx_bus.overrun      = overrun;
    rx_bus.fifo_count   = count;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed frames plus randomized
// frames/pops, compared against a frame-level queue model.
module tb_uart_rx_fifo;
  localparam int DATA_BITS  = 8;
  localparam int OVS        = 16;
  localparam int STOP_BITS  = 1;
  localparam int FIFO_DEPTH = 4;
  localparam int TDIV       = 4;
  localparam int BITCLK     = OVS * TDIV;

  logic i_clk = 1'b0;
  logic i_reset = 1'b1;
  logic i_rxclken = 1'b0;
  logic i_rx = 1'b1;
  logic i_rxclear = 1'b0;
  logic i_parity_en = 1'b0;
  logic i_parity_odd = 1'b0;

  uart_rx_fifo_if #(.DATA_BITS(DATA_BITS), .FIFO_DEPTH(FIFO_DEPTH)) rx_bus ();

  uart_rx_fifo #(
    .DATA_BITS(DATA_BITS), .OVS(OVS), .STOP_BITS(STOP_BITS), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_rxclken(i_rxclken), .i_rx(i_rx),
    .i_rxclear(i_rxclear), .i_parity_en(i_parity_en), .i_parity_odd(i_parity_odd),
    .rx_bus(rx_bus)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    int tdiv_cnt;
    tdiv_cnt = 0;
    forever begin
      @(negedge i_clk);
      tdiv_cnt = (tdiv_cnt + 1) % TDIV;
      i_rxclken = (tdiv_cnt == 0);
    end
  end

  typedef struct {
    logic [7:0] d;
    logic       perr;
    logic       ferr;
  } ent_t;

  ent_t q[$];
  bit   m_ovr;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_push(input logic [7:0] d, input logic perr, input logic ferr);
    ent_t e;
    e.d = d;
    e.perr = perr;
    e.ferr = ferr;
    if (q.size() < FIFO_DEPTH) q.push_back(e);
    else m_ovr = 1'b1;
  endfunction

  task automatic check_state(input string tag);
    chk($sformatf("%s.count", tag), 32'(rx_bus.fifo_count), 32'(q.size()));
    chk($sformatf("%s.valid", tag), 32'(rx_bus.rxvalid), 32'(q.size() != 0));
    chk($sformatf("%s.ovr", tag), 32'(rx_bus.overrun), 32'(m_ovr));
    if (q.size() != 0) begin
      chk($sformatf("%s.data", tag), 32'(rx_bus.rxdata), 32'(q[0].d));
      chk($sformatf("%s.perr", tag), 32'(rx_bus.parity_err), 32'(q[0].perr));
      chk($sformatf("%s.ferr", tag), 32'(rx_bus.frame_err), 32'(q[0].ferr));
    end else begin
      chk($sformatf("%s.data0", tag), 32'(rx_bus.rxdata), 32'h0);
      chk($sformatf("%s.flags0", tag), 32'({rx_bus.parity_err, rx_bus.frame_err}), 32'h0);
    end
  endtask

  task automatic send_bit(input logic v);
    i_rx = v;
    repeat (BITCLK) @(negedge i_clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit pbad, input bit stop_v);
    send_bit(1'b0);
    for (int i = 0; i < DATA_BITS; i++) send_bit(d[i]);
    if (i_parity_en) send_bit((^d) ^ i_parity_odd ^ pbad);
    for (int i = 0; i < STOP_BITS; i++) send_bit(stop_v);
    send_bit(1'b1);
    model_push(d, i_parity_en & pbad, ~stop_v);
  endtask

  task automatic do_pop(input string tag);
    check_state($sformatf("%s.pre", tag));
    rx_bus.rxready = 1'b1;
    @(negedge i_clk);
    rx_bus.rxready = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
    check_state($sformatf("%s.post", tag));
  endtask

  initial begin
    rx_bus.rxready = 1'b0;
    m_ovr = 1'b0;
    repeat (3) @(negedge i_clk);
    check_state("in_reset");
    i_reset = 1'b0;
    repeat (2) @(negedge i_clk);
    check_state("after_reset");

    send_frame(8'hA5, 1'b0, 1'b1);
    check_state("a5");
    do_pop("a5_pop");

    i_rx = 1'b0;
    repeat (3 * TDIV) @(negedge i_clk);
    i_rx = 1'b1;
    repeat (2 * BITCLK) @(negedge i_clk);
    check_state("glitch");

    i_parity_en = 1'b1;
    i_parity_odd = 1'b0;
    send_frame(8'h03, 1'b1, 1'b1);
    check_state("par_bad");
    do_pop("par_bad_pop");
    send_frame(8'h03, 1'b0, 1'b1);
    check_state("par_ok");
    do_pop("par_ok_pop");
    i_parity_en = 1'b0;

    send_frame(8'h55, 1'b0, 1'b0);
    check_state("stop0");
    do_pop("stop0_pop");

    i_rx = 1'b0;
    repeat (20 * BITCLK) @(negedge i_clk);
    i_rx = 1'b1;
    repeat (2 * BITCLK) @(negedge i_clk);
    model_push(8'h00, 1'b0, 1'b1);
    check_state("break");
    send_frame(8'h3C, 1'b0, 1'b1);
    check_state("after_break");
    do_pop("brk_pop");
    do_pop("3c_pop");

    for (int i = 0; i < 5; i++) send_frame(8'(8'h10 + i), 1'b0, 1'b1);
    check_state("ovr_full");
    for (int i = 0; i < 4; i++) do_pop($sformatf("ovr_pop%0d", i));
    do_pop("pop_empty");

    send_frame(8'h21, 1'b0, 1'b1);
    send_frame(8'h42, 1'b0, 1'b1);
    check_state("pre_clear");
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    i_rxclear = 1'b1;
    @(negedge i_clk);
    i_rxclear = 1'b0;
    q.delete();
    m_ovr = 1'b0;
    check_state("clear");
    repeat (2 * BITCLK) @(negedge i_clk);
    send_frame(8'h7E, 1'b0, 1'b1);
    check_state("after_clear");
    do_pop("7e_pop");

    for (int n = 0; n < 25; n++) begin
      logic [7:0] d;
      bit pbad, stop_v;
      int npop;
      i_parity_en  = 1'($urandom_range(0, 1));
      i_parity_odd = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      pbad = i_parity_en && ($urandom_range(0, 3) == 0);
      stop_v = ($urandom_range(0, 7) != 0);
      send_frame(d, pbad, stop_v);
      check_state($sformatf("rnd%0d", n));
      npop = $urandom_range(0, 2);
      for (int k = 0; k < npop; k++) do_pop($sformatf("rnd%0d_pop%0d", n, k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
